axi_mem_sram_bridge: RTL and testbench

- AXI4 slave that terminates the core's 64-bit AXI master port and serves one on-chip SRAM region (IMEM or DMEM; one instance per region).
- Converts AXI bursts into single-beat SRAM accesses, one burst at a time, arbitrating between reads and writes.
- Generates OKAY, SLVERR and DECERR responses.

---
 rtl/axi_mem_sram_bridge.sv | 274 +++++++++++++++++++++++++++
 tb/tb_axi_mem_sram_bridge.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_sram_bridge
// Brief    : AXI4 slave serving one on-chip SRAM region. Bursts are split
//            into single-beat SRAM accesses, one burst at a time, with a
//            read/write arbiter and OKAY/SLVERR/DECERR response generation.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_sram_bridge #(
    parameter int unsigned AXI_ID_WIDTH = 4,
    parameter logic [63:0] MEM_BASE     = 64'h0000_0000_0004_0000,
    parameter logic [63:0] MEM_LENGTH   = 64'h0000_0000_0000_4000,
    parameter int unsigned SRAM_AW      = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // write address channel
    input  logic [AXI_ID_WIDTH-1:0] axi_awid,
    input  logic [63:0]             axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic [5:0]              axi_awatop,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    // write data channel
    input  logic [63:0]             axi_wdata,
    input  logic [7:0]              axi_wstrb,
    input  logic                    axi_wlast,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    // write response channel
    output logic [AXI_ID_WIDTH-1:0] axi_bid,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    // read address channel
    input  logic [AXI_ID_WIDTH-1:0] axi_arid,
    input  logic [63:0]             axi_araddr,
    input  logic [7:0]              axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    // read data channel
    output logic [AXI_ID_WIDTH-1:0] axi_rid,
    output logic [63:0]             axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    // SRAM port
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [SRAM_AW-1:0]      sram_addr_o,
    output logic [63:0]             sram_wdata_o,
    output logic [7:0]              sram_be_o,
    input  logic [63:0]             sram_rdata_i
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WDATA  = 2'd1;
    localparam logic [1:0] c_ST_WRESP  = 2'd2;
    localparam logic [1:0] c_ST_RDATA  = 2'd3;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [64:0] c_REGION_END = {1'b0, MEM_BASE} + {1'b0, MEM_LENGTH};

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_prio_wr;
    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [SRAM_AW-1:0]      r_addr;
    logic [7:0]              r_len;
    logic [1:0]              r_err;
    logic                    r_fixed;
    logic [7:0]              r_beat;
    logic [8:0]              r_issue_cnt;
    logic                    r_inflight;
    logic [63:0]             r_fifo [2];
    logic                    r_wptr;
    logic                    r_rptr;
    logic [1:0]              r_occ;

    logic                    w_idle;
    logic                    w_sel_wr;
    logic                    w_sel_rd;
    logic                    w_aw_hs;
    logic                    w_ar_hs;
    logic [AXI_ID_WIDTH-1:0] w_req_id;
    logic [63:0]             w_req_addr;
    logic [7:0]              w_req_len;
    logic [2:0]              w_req_size;
    logic [1:0]              w_req_burst;
    logic [5:0]              w_req_atop;
    logic [64:0]             w_req_end;
    logic [63:0]             w_req_offset;
    logic [SRAM_AW-1:0]      w_req_word;
    logic                    w_decerr;
    logic                    w_slverr;
    logic [1:0]              w_req_err;
    logic                    w_w_hs;
    logic                    w_w_last;
    logic                    w_pop;
    logic                    w_r_last;
    logic [1:0]              w_outstanding;
    logic                    w_issue;
    logic                    w_unused;

    // Arbitration: a lone valid wins; on a tie the priority holder wins.
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_sel_wr = axi_awvalid && (!axi_arvalid || r_prio_wr);
    assign w_sel_rd = axi_arvalid && (!axi_awvalid || !r_prio_wr);
    assign w_aw_hs  = w_idle && w_sel_wr;
    assign w_ar_hs  = w_idle && w_sel_rd;

    // The selected request is classified once, for whichever channel won.
    assign w_req_id    = w_sel_wr ? axi_awid    : axi_arid;
    assign w_req_addr  = w_sel_wr ? axi_awaddr  : axi_araddr;
    assign w_req_len   = w_sel_wr ? axi_awlen   : axi_arlen;
    assign w_req_size  = w_sel_wr ? axi_awsize  : axi_arsize;
    assign w_req_burst = w_sel_wr ? axi_awburst : axi_arburst;
    assign w_req_atop  = w_sel_wr ? axi_awatop  : 6'd0;

    // Last byte touched = addr + len*8 + 7, kept in 65 bits so it cannot wrap.
    assign w_req_end    = {1'b0, w_req_addr} + {54'd0, w_req_len, 3'b111};
    assign w_decerr     = (w_req_addr < MEM_BASE) || (w_req_end >= c_REGION_END);
    assign w_slverr     = (w_req_size != 3'd3) || (w_req_burst == c_BURST_WRAP) ||
                          (w_req_addr[2:0] != 3'd0) || (w_req_atop != 6'd0);
    assign w_req_err    = w_decerr ? c_RESP_DECERR :
                          w_slverr ? c_RESP_SLVERR : c_RESP_OKAY;
    assign w_req_offset = w_req_addr - MEM_BASE;
    assign w_req_word   = w_req_offset[SRAM_AW+2:3];

    // Write beats: termination is counted from len, wlast is not trusted.
    assign w_w_hs   = (r_state == c_ST_WDATA) && axi_wvalid;
    assign w_w_last = (r_beat == r_len);

    // Read path: occupancy after this cycle's pop plus the read in flight
    // never exceeds the two FIFO entries, which still allows one beat/cycle.
    assign w_pop         = axi_rvalid && axi_rready;
    assign w_r_last      = (r_beat == r_len);
    assign w_outstanding = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue       = (r_state == c_ST_RDATA) &&
                           (r_issue_cnt <= {1'b0, r_len}) &&
                           (w_outstanding < 2'd2);

    assign axi_awready = w_aw_hs;
    assign axi_arready = w_ar_hs;
    assign axi_wready  = (r_state == c_ST_WDATA);
    assign axi_bvalid  = (r_state == c_ST_WRESP);
    assign axi_bid     = r_id;
    assign axi_bresp   = r_err;
    assign axi_rvalid  = (r_state == c_ST_RDATA) && (r_occ != 2'd0);
    assign axi_rdata   = r_fifo[r_rptr];
    assign axi_rresp   = r_err;
    assign axi_rlast   = w_r_last;
    assign axi_rid     = r_id;

    // Errored bursts walk through every beat but never touch the SRAM.
    assign sram_req_o   = (r_err == c_RESP_OKAY) && (w_w_hs || w_issue);
    assign sram_we_o    = (r_state == c_ST_WDATA);
    assign sram_addr_o  = r_addr;
    assign sram_wdata_o = axi_wdata;
    assign sram_be_o    = (r_state == c_ST_WDATA) ? axi_wstrb : 8'd0;

    assign w_unused = ^{axi_wlast, w_req_offset[63:SRAM_AW+3], w_req_offset[2:0]};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one burst at a time, back to IDLE after the response.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_aw_hs) begin
                    w_state_nxt = c_ST_WDATA;
                end else if (w_ar_hs) begin
                    w_state_nxt = c_ST_RDATA;
                end
            end
            c_ST_WDATA: begin
                if (w_w_hs && w_w_last) begin
                    w_state_nxt = c_ST_WRESP;
                end
            end
            c_ST_WRESP: begin
                if (axi_bready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RDATA: begin
                if (w_pop && w_r_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Burst context, beat counters, arbitration priority and FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio_wr   <= 1'b1;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= 8'd0;
            r_err       <= c_RESP_OKAY;
            r_fixed     <= 1'b0;
            r_beat      <= 8'd0;
            r_issue_cnt <= 9'd0;
            r_inflight  <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            if (w_aw_hs || w_ar_hs) begin
                r_id        <= w_req_id;
                r_addr      <= w_req_word;
                r_len       <= w_req_len;
                r_err       <= w_req_err;
                r_fixed     <= (w_req_burst == c_BURST_FIXED);
                r_beat      <= 8'd0;
                r_issue_cnt <= 9'd0;
                if (axi_awvalid && axi_arvalid) begin
                    r_prio_wr <= ~r_prio_wr;
                end
            end
            if (w_w_hs) begin
                r_beat <= r_beat + 8'd1;
                if (!r_fixed) begin
                    r_addr <= r_addr + SRAM_AW'(1);
                end
            end
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 9'd1;
                if (!r_fixed) begin
                    r_addr <= r_addr + SRAM_AW'(1);
                end
            end
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
                r_beat <= r_beat + 8'd1;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Read data lands one cycle after its strobe; errored bursts return zero.
    always_ff @(posedge clk_i) begin
        if (r_inflight) begin
            r_fifo[r_wptr] <= (r_err == c_RESP_OKAY) ? sram_rdata_i : 64'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_sram_bridge
// Brief    : Self-checking bench for axi_mem_sram_bridge: directed scenarios
//            plus randomized bursts against a word-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_sram_bridge;

    localparam int unsigned IDW        = 4;
    localparam logic [63:0] MEM_BASE   = 64'h0000_0000_0004_0000;
    localparam logic [63:0] MEM_LENGTH = 64'h0000_0000_0000_4000;
    localparam int unsigned NWORDS     = 2048;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [IDW-1:0]  axi_awid = '0;
    logic [63:0]     axi_awaddr = '0;
    logic [7:0]      axi_awlen = '0;
    logic [2:0]      axi_awsize = '0;
    logic [1:0]      axi_awburst = '0;
    logic [5:0]      axi_awatop = '0;
    logic            axi_awvalid = 1'b0;
    logic            axi_awready;
    logic [63:0]     axi_wdata = '0;
    logic [7:0]      axi_wstrb = '0;
    logic            axi_wlast = 1'b0;
    logic            axi_wvalid = 1'b0;
    logic            axi_wready;
    logic [IDW-1:0]  axi_bid;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid;
    logic            axi_bready = 1'b0;
    logic [IDW-1:0]  axi_arid = '0;
    logic [63:0]     axi_araddr = '0;
    logic [7:0]      axi_arlen = '0;
    logic [2:0]      axi_arsize = '0;
    logic [1:0]      axi_arburst = '0;
    logic            axi_arvalid = 1'b0;
    logic            axi_arready;
    logic [IDW-1:0]  axi_rid;
    logic [63:0]     axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rlast;
    logic            axi_rvalid;
    logic            axi_rready = 1'b0;
    logic            sram_req_o;
    logic            sram_we_o;
    logic [10:0]     sram_addr_o;
    logic [63:0]     sram_wdata_o;
    logic [7:0]      sram_be_o;
    logic [63:0]     sram_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] ref_mem [NWORDS];
    logic [63:0] sram_mem [NWORDS];
    bit          sram_wr [NWORDS];
    int          out_cnt = 0;
    int          out_max = 0;

    axi_mem_sram_bridge #(
        .AXI_ID_WIDTH (IDW),
        .MEM_BASE     (MEM_BASE),
        .MEM_LENGTH   (MEM_LENGTH),
        .SRAM_AW      (11)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .axi_awid     (axi_awid),
        .axi_awaddr   (axi_awaddr),
        .axi_awlen    (axi_awlen),
        .axi_awsize   (axi_awsize),
        .axi_awburst  (axi_awburst),
        .axi_awatop   (axi_awatop),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wlast    (axi_wlast),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bid      (axi_bid),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready),
        .axi_arid     (axi_arid),
        .axi_araddr   (axi_araddr),
        .axi_arlen    (axi_arlen),
        .axi_arsize   (axi_arsize),
        .axi_arburst  (axi_arburst),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rid      (axi_rid),
        .axi_rdata    (axi_rdata),
        .axi_rresp    (axi_rresp),
        .axi_rlast    (axi_rlast),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_be_o    (sram_be_o),
        .sram_rdata_i (sram_rdata_i)
    );

    always #5 clk = ~clk;

    // Power-on content of every SRAM word, distinct per address.
    function automatic logic [63:0] init_pat(input int unsigned a);
        return {(a * 32'h9E37_79B1) ^ 32'h1234_5678, ~(a * 32'h85EB_CA6B)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_err(input logic [63:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input logic [5:0] atop);
        logic [64:0] last_byte;
        logic [64:0] limit;
        last_byte = 65'(addr) + 65'(len) * 65'd8 + 65'd7;
        limit     = 65'(MEM_BASE) + 65'(MEM_LENGTH);
        if (addr < MEM_BASE || last_byte >= limit) return 2'b11;
        if (size != 3'd3 || burst == 2'b10 || addr[2:0] != 3'd0 || atop != 6'd0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int unsigned word_of(input logic [63:0] addr);
        logic [63:0] off;
        off = (addr - MEM_BASE) >> 3;
        return int'(off[10:0]);
    endfunction

    // Synchronous SRAM: writes merge bytes, read data appears the next cycle.
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                sram_mem[sram_addr_o] <= merge(sram_wr[sram_addr_o] ? sram_mem[sram_addr_o]
                                               : init_pat(32'(sram_addr_o)),
                                               sram_wdata_o, sram_be_o);
                sram_wr[sram_addr_o]  <= 1'b1;
            end else begin
                sram_rdata_i <= sram_wr[sram_addr_o] ? sram_mem[sram_addr_o]
                                : init_pat(32'(sram_addr_o));
            end
        end
    end

    // Reads issued to the SRAM but not yet handed out on R.
    always @(posedge clk) begin
        int nxt;
        if (rst_i) begin
            out_cnt <= 0;
        end else begin
            nxt = out_cnt + ((sram_req_o && !sram_we_o) ? 1 : 0)
                  - ((axi_rvalid && axi_rready && axi_rresp == 2'b00) ? 1 : 0);
            out_cnt <= nxt;
            if (nxt > out_max) out_max <= nxt;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] atop,
                            input bit aw_done, input bit fixed_data,
                            input logic [63:0] d0, input logic [7:0] s0);
        logic [1:0]  err;
        int          n;
        int unsigned w0;
        int unsigned wa;
        logic [63:0] d;
        logic [7:0]  s;
        err = exp_err(addr, len, size, burst, atop);
        w0  = word_of(addr);
        if (!aw_done) begin
            axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size;
            axi_awburst = burst; axi_awatop = atop; axi_awvalid = 1'b1;
            #1;
            n = 0;
            while (!axi_awready && n < 50) begin step(); #1; n++; end
            check_eq("aw_ready", 64'(axi_awready), 64'd1);
            step();
            axi_awvalid = 1'b0;
        end
        for (int b = 0; b <= int'(len); b++) begin
            axi_wvalid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            d = fixed_data ? d0 : {$urandom, $urandom};
            s = fixed_data ? s0 : 8'($urandom);
            axi_wdata = d; axi_wstrb = s; axi_wlast = (b == int'(len)); axi_wvalid = 1'b1;
            #1;
            check_eq("w_ready", 64'(axi_wready), 64'd1);
            check_eq("w_req", 64'(sram_req_o), 64'(err == 2'b00));
            if (err == 2'b00) begin
                wa = (w0 + ((burst == 2'b01) ? b : 0)) % NWORDS;
                check_eq("w_we", 64'(sram_we_o), 64'd1);
                check_eq("w_addr", 64'(sram_addr_o), 64'(wa));
                check_eq("w_data", sram_wdata_o, d);
                check_eq("w_be", 64'(sram_be_o), 64'(s));
                ref_mem[wa] = merge(ref_mem[wa], d, s);
            end
            step();
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        #1;
        check_eq("b_valid", 64'(axi_bvalid), 64'd1);
        check_eq("b_resp", 64'(axi_bresp), 64'(err));
        check_eq("b_id", 64'(axi_bid), 64'(id));
        n = $urandom_range(0, 2);
        repeat (n) begin
            step();
            #1;
            check_eq("b_hold", 64'({axi_bvalid, axi_bresp}), 64'({1'b1, err}));
        end
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        #1;
        check_eq("b_done", 64'(axi_bvalid), 64'd0);
    endtask

    // mode 0: rready held high, 1: toggling 1010..., 2: random.
    task automatic do_read(input logic [IDW-1:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit ar_done,
                           input int mode, input bit chk_lat);
        logic [1:0]  err;
        int          n;
        int          beat;
        int          cyc;
        int unsigned w0;
        logic [63:0] held;
        logic [63:0] exp;
        bit          stalled;
        err = exp_err(addr, len, size, burst, 6'd0);
        w0  = word_of(addr);
        if (!ar_done) begin
            axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = size;
            axi_arburst = burst; axi_arvalid = 1'b1;
            #1;
            n = 0;
            while (!axi_arready && n < 50) begin step(); #1; n++; end
            check_eq("ar_ready", 64'(axi_arready), 64'd1);
            step();
            axi_arvalid = 1'b0;
        end
        beat = 0; cyc = 1; stalled = 1'b0; held = '0;
        while (beat <= int'(len) && cyc < 300) begin
            case (mode)
                0:       axi_rready = 1'b1;
                1:       axi_rready = cyc[0];
                default: axi_rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stalled) begin
                check_eq("r_hold_valid", 64'(axi_rvalid), 64'd1);
                check_eq("r_hold_data", axi_rdata, held);
            end
            if (axi_rvalid) begin
                if (chk_lat) check_eq("r_cycle", 64'(cyc), 64'(3 + beat));
                if (axi_rready) begin
                    exp = (err != 2'b00) ? 64'd0
                          : ref_mem[(w0 + ((burst == 2'b01) ? beat : 0)) % NWORDS];
                    check_eq("r_data", axi_rdata, exp);
                    check_eq("r_resp", 64'(axi_rresp), 64'(err));
                    check_eq("r_last", 64'(axi_rlast), 64'(beat == int'(len)));
                    check_eq("r_id", 64'(axi_rid), 64'(id));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = axi_rdata;
                end
            end
            step();
            cyc++;
        end
        axi_rready = 1'b0;
        check_eq("r_beats", 64'(beat), 64'(int'(len) + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          n;
        int          kind;
        int unsigned wd;
        logic [7:0]  len;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;

        for (int i = 0; i < int'(NWORDS); i++) ref_mem[i] = init_pat(32'(i));

        // Reset state
        rst_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        #1;
        check_eq("rst_outputs",
                 64'({axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, sram_req_o}),
                 64'd0);
        step();

        // Simultaneous AW/AR after reset: write goes first
        axi_awid = 4'h1; axi_awaddr = MEM_BASE + 64'h100; axi_awlen = 8'd1; axi_awsize = 3'd3;
        axi_awburst = 2'b01; axi_awatop = 6'd0; axi_awvalid = 1'b1;
        axi_arid = 4'h2; axi_araddr = MEM_BASE + 64'h100; axi_arlen = 8'd1; axi_arsize = 3'd3;
        axi_arburst = 2'b01; axi_arvalid = 1'b1;
        #1;
        check_eq("arb1_aw", 64'(axi_awready), 64'd1);
        check_eq("arb1_ar", 64'(axi_arready), 64'd0);
        step();
        axi_awvalid = 1'b0;
        do_write(4'h1, MEM_BASE + 64'h100, 8'd1, 3'd3, 2'b01, 6'd0, 1'b1, 1'b0, '0, '0);
        do_read(4'h2, MEM_BASE + 64'h100, 8'd1, 3'd3, 2'b01, 1'b0, 0, 1'b0);

        // Next simultaneous pair: read goes first
        axi_awid = 4'h3; axi_awaddr = MEM_BASE + 64'h200; axi_awlen = 8'd0; axi_awsize = 3'd3;
        axi_awburst = 2'b01; axi_awatop = 6'd0; axi_awvalid = 1'b1;
        axi_arid = 4'h4; axi_araddr = MEM_BASE + 64'h300; axi_arlen = 8'd2; axi_arsize = 3'd3;
        axi_arburst = 2'b01; axi_arvalid = 1'b1;
        #1;
        check_eq("arb2_ar", 64'(axi_arready), 64'd1);
        check_eq("arb2_aw", 64'(axi_awready), 64'd0);
        step();
        axi_arvalid = 1'b0;
        do_read(4'h4, MEM_BASE + 64'h300, 8'd2, 3'd3, 2'b01, 1'b1, 0, 1'b1);
        do_write(4'h3, MEM_BASE + 64'h200, 8'd0, 3'd3, 2'b01, 6'd0, 1'b0, 1'b0, '0, '0);

        // Single write to word 1
        do_write(4'h5, 64'h4_0008, 8'd0, 3'd3, 2'b01, 6'd0, 1'b0, 1'b1,
                 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        // Read burst of words 0-3, back-to-back, latency checked
        do_read(4'hA, 64'h4_0000, 8'd3, 3'd3, 2'b01, 1'b0, 0, 1'b1);
        // Same read under toggling backpressure
        do_read(4'hB, 64'h4_0000, 8'd3, 3'd3, 2'b01, 1'b0, 1, 1'b0);
        // Out of range write, in-range read with size 2
        do_write(4'h6, 64'h4_4000, 8'd1, 3'd3, 2'b01, 6'd0, 1'b0, 1'b0, '0, '0);
        do_read(4'h7, 64'h4_0040, 8'd1, 3'd2, 2'b01, 1'b0, 2, 1'b0);
        // Top-of-region boundary: last word legal, one word further is DECERR
        do_read(4'h8, MEM_BASE + 64'h3FE0, 8'd3, 3'd3, 2'b01, 1'b0, 0, 1'b0);
        do_read(4'h9, MEM_BASE + 64'h3FE8, 8'd3, 3'd3, 2'b01, 1'b0, 0, 1'b0);

        // Randomized bursts
        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 11);
            len   = 8'($urandom_range(0, 7));
            wd    = $urandom_range(0, 2047 - int'(len));
            addr  = MEM_BASE + 64'(wd) * 64'd8;
            size  = 3'd3;
            burst = 2'($urandom_range(0, 1));
            atop  = 6'd0;
            case (kind)
                6:  addr = MEM_BASE - 64'($urandom_range(1, 64)) * 64'd8;
                7:  addr = MEM_BASE + 64'(2048 - int'(len) + $urandom_range(0, 3)) * 64'd8;
                8:  size = 3'($urandom_range(0, 2));
                9:  burst = 2'b10;
                10: addr = addr + 64'($urandom_range(1, 7));
                11: atop = 6'($urandom_range(1, 63));
                default: ;
            endcase
            if (kind == 11 || $urandom_range(0, 1) == 1) begin
                do_write(4'($urandom), addr, len, size, burst, atop, 1'b0, 1'b0, '0, '0);
            end else begin
                do_read(4'($urandom), addr, len, size, burst, 1'b0, 2, 1'b0);
            end
        end

        // Reset in the middle of a len-7 read
        axi_arid = 4'hC; axi_araddr = MEM_BASE + 64'h80; axi_arlen = 8'd7; axi_arsize = 3'd3;
        axi_arburst = 2'b01; axi_arvalid = 1'b1;
        #1;
        check_eq("mid_ar_ready", 64'(axi_arready), 64'd1);
        step();
        axi_arvalid = 1'b0;
        axi_rready  = 1'b1;
        acc = 0; n = 0;
        while (acc < 2 && n < 20) begin
            #1;
            if (axi_rvalid) acc++;
            step();
            n++;
        end
        check_eq("mid_beats", 64'(acc), 64'd2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        axi_rready = 1'b0;
        #1;
        check_eq("mid_rvalid", 64'(axi_rvalid), 64'd0);
        check_eq("mid_busy", 64'({axi_wready, axi_bvalid}), 64'd0);
        step();
        do_read(4'hD, MEM_BASE + 64'h10, 8'd2, 3'd3, 2'b01, 1'b0, 0, 1'b1);

        check_eq("max_outstanding", 64'(out_max), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
